// File: rtl/sobel_pkg.sv
// sobel_pkg: shared state encoding and width helper for the Sobel window controller
package sobel_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;
  function automatic int coord_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sobel_window_ctrl_if.sv
// sobel_window_ctrl_if: pixel-stream inputs and datapath/frame-writer outputs of the window controller
interface sobel_window_ctrl_if #(parameter int XW = 10, parameter int YW = 9);
  logic iFVAL;
  logic iDVAL;
  logic iVERT_REQ;
  logic oCONV_CLKEN;
  logic oVERTICAL;
  logic oDVAL;
  logic [XW-1:0] oX;
  logic [YW-1:0] oY;
  logic oFRAME_DONE;
  logic oFRAME_ERR;
  modport master (
    output iFVAL, iDVAL, iVERT_REQ,
    input  oCONV_CLKEN, oVERTICAL, oDVAL, oX, oY, oFRAME_DONE, oFRAME_ERR
  );
  modport slave (
    input  iFVAL, iDVAL, iVERT_REQ,
    output oCONV_CLKEN, oVERTICAL, oDVAL, oX, oY, oFRAME_DONE, oFRAME_ERR
  );
endinterface

// File: rtl/sobel_valid_pipe.sv
// sobel_valid_pipe: LAT-deep valid/payload delay; payload stages load only on valid so the output holds
module sobel_valid_pipe #(
  parameter int LAT = 1,
  parameter int DW  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic          out_vld,
  output logic [DW-1:0] out_data
);
  logic [LAT-1:0] vld_q, vld_d;
  logic [DW-1:0]  dat_q [LAT];
  logic [DW-1:0]  dat_d [LAT];
  always_comb begin
    vld_d[0] = in_vld;
    dat_d[0] = in_vld ? in_data : dat_q[0];
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end
  assign out_vld  = vld_q[LAT-1];
  assign out_data = dat_q[LAT-1];
endmodule

// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: raster tracking, line-buffer enable, frame-latched kernel select and interior-result strobe
module sobel_window_ctrl import sobel_pkg::*; #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int LAT        = 1
) (
  input logic iCLK,
  input logic iRST,
  sobel_window_ctrl_if.slave bus
);
  localparam int XW  = coord_w(IMG_WIDTH);
  localparam int YW  = coord_w(IMG_HEIGHT);
  localparam int DCW = coord_w(LAT + 1);
  state_t state_q, state_d;
  logic [XW-1:0]  col_q, col_d;
  logic [YW-1:0]  row_q, row_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic fval_q, vert_q, vert_d, pend_q, pend_d, pvert_q, pvert_d;
  logic rise, in_frame, active, acc, err, last_col, last_row, last, interior, done;
  logic [XW+YW-1:0] res_xy;
  always_comb begin
    rise     = bus.iFVAL & ~fval_q;
    in_frame = (state_q == FILL) | (state_q == RUN);
    active   = in_frame | ((state_q == IDLE) & rise);
    acc      = active & bus.iFVAL & bus.iDVAL;
    err      = in_frame & ~bus.iFVAL;
    last_col = col_q == XW'(IMG_WIDTH - 1);
    last_row = row_q == YW'(IMG_HEIGHT - 1);
    last     = acc & last_col & last_row;
    interior = acc & (col_q >= XW'(2)) & (row_q >= YW'(2));
    // DRAIN spans LAT+1 cycles so done lands one cycle after the final result
    done     = (state_q == DRAIN) & (dcnt_q == DCW'(LAT));
    col_d    = (!active || err || (acc && last_col)) ? '0 : acc ? col_q + 1'b1 : col_q;
    row_d    = (!active || err || last) ? '0 : (acc && last_col) ? row_q + 1'b1 : row_q;
    dcnt_d   = ((state_q == DRAIN) && !done) ? dcnt_q + 1'b1 : '0;
    pend_d   = (state_q == DRAIN) & ~done & (pend_q | rise);
    pvert_d  = ((state_q == DRAIN) && rise && !pend_q) ? bus.iVERT_REQ : pvert_q;
    state_d  = state_q;
    vert_d   = vert_q;
    case (state_q)
      IDLE: begin
        state_d = rise ? FILL : IDLE;
        vert_d  = rise ? bus.iVERT_REQ : vert_q;
      end
      FILL:  state_d = (err || last) ? DRAIN : (row_d == YW'(2)) ? RUN : FILL;
      RUN:   state_d = (err || last) ? DRAIN : RUN;
      DRAIN: begin
        state_d = !done ? DRAIN : (pend_q || rise) ? FILL : IDLE;
        vert_d  = !done ? vert_q : pend_q ? pvert_q : rise ? bus.iVERT_REQ : vert_q;
      end
    endcase
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      dcnt_q  <= '0;
      fval_q  <= 1'b1;
      vert_q  <= 1'b1;
      pend_q  <= 1'b0;
      pvert_q <= 1'b1;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      dcnt_q  <= dcnt_d;
      fval_q  <= bus.iFVAL;
      vert_q  <= vert_d;
      pend_q  <= pend_d;
      pvert_q <= pvert_d;
    end
  end
  sobel_valid_pipe #(.LAT(LAT), .DW(XW + YW)) u_pipe (
    .clk      (iCLK),
    .rst      (iRST),
    .in_vld   (interior),
    .in_data  ({col_q - 1'b1, row_q - 1'b1}),
    .out_vld  (bus.oDVAL),
    .out_data (res_xy)
  );
  assign {bus.oX, bus.oY} = res_xy;
  assign bus.oCONV_CLKEN  = acc;
  assign bus.oVERTICAL    = vert_q;
  assign bus.oFRAME_DONE  = done;
  assign bus.oFRAME_ERR   = err;
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb_sobel_window_ctrl: directed frames driven into LAT=1 and LAT=3 instances against a cycle-indexed expectation table
module tb_sobel_window_ctrl;
  import sobel_pkg::*;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = 4096;
  localparam int XW = coord_w(W);
  localparam int YW = coord_w(H);
  logic clk = 0, rst = 1, fval = 0, dval = 0, vreq = 1;
  always #5 clk = ~clk;
  sobel_window_ctrl_if #(.XW(XW), .YW(YW)) bus_a ();
  sobel_window_ctrl_if #(.XW(XW), .YW(YW)) bus_b ();
  assign bus_a.iFVAL = fval;
  assign bus_a.iDVAL = dval;
  assign bus_a.iVERT_REQ = vreq;
  assign bus_b.iFVAL = fval;
  assign bus_b.iDVAL = dval;
  assign bus_b.iVERT_REQ = vreq;
  sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .LAT(1)) dut_a (.iCLK(clk), .iRST(rst), .bus(bus_a));
  sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .LAT(3)) dut_b (.iCLK(clk), .iRST(rst), .bus(bus_b));
  int ncmp = 0, nerr = 0, cy = 0, k = 0;
  int lat [2] = '{1, 3};
  int nres [2];
  bit exp_dv [2][N];
  bit exp_done [2][N];
  logic [XW-1:0] exp_x [2][N];
  logic [YW-1:0] exp_y [2][N];
  logic [XW-1:0] lx [2];
  logic [YW-1:0] ly [2];
  bit exp_err = 0, exp_vert = 1;

  task automatic chk(input string tag, input int j, input logic [31:0] o, input logic [31:0] e);
    ncmp++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s[lat%0d] cycle %0d: observed %0d expected %0d", tag, lat[j], cy, o, e);
    end
  endtask

  task automatic mon(input int j, input logic dv, input logic [XW-1:0] x, input logic [YW-1:0] y,
                     input logic dn, input logic er, input logic ce, input logic vt, input bit acc);
    if (exp_dv[j][cy]) begin
      lx[j] = exp_x[j][cy];
      ly[j] = exp_y[j][cy];
    end
    chk("dval", j, 32'(dv), 32'(exp_dv[j][cy]));
    chk("x", j, 32'(x), 32'(lx[j]));
    chk("y", j, 32'(y), 32'(ly[j]));
    chk("done", j, 32'(dn), 32'(exp_done[j][cy]));
    chk("err", j, 32'(er), 32'(exp_err));
    chk("clken", j, 32'(ce), 32'(acc));
    chk("vertical", j, 32'(vt), 32'(exp_vert));
    if (dv === 1'b1) nres[j]++;
  endtask

  task automatic cyc(input bit r, input bit f, input bit d, input bit v, input bit acc);
    int col, row;
    rst = r; fval = f; dval = d; vreq = v;
    #2;
    if (!r) begin
      mon(0, bus_a.oDVAL, bus_a.oX, bus_a.oY, bus_a.oFRAME_DONE, bus_a.oFRAME_ERR, bus_a.oCONV_CLKEN, bus_a.oVERTICAL, acc);
      mon(1, bus_b.oDVAL, bus_b.oX, bus_b.oY, bus_b.oFRAME_DONE, bus_b.oFRAME_ERR, bus_b.oCONV_CLKEN, bus_b.oVERTICAL, acc);
    end else begin
      for (int j = 0; j < 2; j++) begin
        lx[j] = '0;
        ly[j] = '0;
        for (int i = cy + 1; i < cy + 6; i++) begin
          exp_dv[j][i] = 0;
          exp_done[j][i] = 0;
        end
      end
    end
    if (acc) begin
      col = k % W;
      row = k / W;
      for (int j = 0; j < 2; j++) begin
        if (col >= 2 && row >= 2) begin
          exp_dv[j][cy + lat[j]] = 1;
          exp_x[j][cy + lat[j]] = XW'(col - 1);
          exp_y[j][cy + lat[j]] = YW'(row - 1);
        end
        if (k == W * H - 1) exp_done[j][cy + lat[j] + 1] = 1;
      end
      k++;
    end
    @(negedge clk);
    cy++;
  endtask

  // nb beats (short of W*H means iFVAL drops early), pre idle-valid cycles, tail post-frame beats offered, post idle cycles
  task automatic frame(input int nb, input bit gap, input bit v0, input bit vtog, input int pre, input int tail, input int post);
    int sent;
    bit d, v, first;
    sent = 0;
    first = 1;
    v = v0;
    k = 0;
    for (int i = 0; i < pre; i++) begin
      cyc(0, 1, 0, v0, 0);
      if (first) exp_vert = v0;
      first = 0;
    end
    for (int i = 0; i < 1000 && sent < nb; i++) begin
      d = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      v = (vtog && sent >= 10) ? ~v0 : v0;
      cyc(0, 1, d, v, d);
      if (first) exp_vert = v0;
      first = 0;
      sent += int'(d);
    end
    if (nb < W * H) begin
      exp_err = 1;
      for (int j = 0; j < 2; j++) exp_done[j][cy + lat[j] + 1] = 1;
      cyc(0, 0, 0, v, 0);
      exp_err = 0;
    end
    for (int i = 0; i < tail; i++) cyc(0, 1, 1, v, 0);
    for (int i = 0; i < post; i++) cyc(0, 0, 0, v, 0);
  endtask

  task automatic count_check(input int want);
    for (int j = 0; j < 2; j++) begin
      chk("results", j, 32'(nres[j]), 32'(want));
      nres[j] = 0;
    end
  endtask

  initial begin
    nres = '{0, 0};
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    frame(48, 0, 1, 0, 0, 2, 8);
    count_check(24);
    frame(48, 1, 0, 1, 0, 2, 8);
    count_check(24);
    frame(48, 0, 1, 0, 0, 2, 8);
    count_check(24);
    frame(20, 0, 1, 0, 0, 0, 8);
    count_check(2);
    frame(48, 0, 1, 0, 0, 2, 8);
    count_check(24);
    k = 0;
    for (int i = 0; i < 30; i++) cyc(0, 1, 1, 1, 1);
    cyc(1, 1, 1, 1, 0);
    nres = '{0, 0};
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 1, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 1, 0);
    count_check(0);
    frame(48, 0, 1, 0, 0, 2, 8);
    count_check(24);
    frame(48, 0, 1, 0, 0, 0, 1);
    frame(48, 0, 1, 0, 3, 2, 10);
    count_check(48);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
